// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/timing generator with ROI window and pixel clock-enable
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int WIN_X0   = 288,
   parameter int WIN_Y0   = 208,
   parameter int WIN_W    = 64,
   parameter int WIN_H    = 64,
   parameter int CW       = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_ce,
   output logic          h_sync,
   output logic          v_sync,
   output logic          active_video,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          line_start,
   output logic          frame_start,
   output logic          win_active,
   output logic [CW-1:0] win_x,
   output logic [CW-1:0] win_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] WX_BEG   = CW'(WIN_X0);
   localparam logic [CW-1:0] WX_END   = CW'(WIN_X0 + WIN_W);
   localparam logic [CW-1:0] WY_BEG   = CW'(WIN_Y0);
   localparam logic [CW-1:0] WY_END   = CW'(WIN_Y0 + WIN_H);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic          HP       = (H_POL != 0);
   localparam logic          VP       = (V_POL != 0);

   if (WIN_X0 + WIN_W > H_ACTIVE) begin : g_chk_win_x
      $error("vga_timing_gen: window exceeds active width");
   end
   if (WIN_Y0 + WIN_H > V_ACTIVE) begin : g_chk_win_y
      $error("vga_timing_gen: window exceeds active height");
   end
   if ((64'd1 << CW) <= 64'(MAX_TOTAL)) begin : g_chk_cw
      $error("vga_timing_gen: CW too narrow for line/frame totals");
   end

   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          act_d;
   logic          hs_d;
   logic          vs_d;
   logic          win_d;

   // Decode works on the pre-advance position; outputs register it on the same ce edge.
   always_comb begin
      act_d = (x < H_ACT) && (y < V_ACT);
      hs_d  = (x >= HS_BEG) && (x < HS_END);
      vs_d  = (y >= VS_BEG) && (y < VS_END);
      win_d = (x >= WX_BEG) && (x < WX_END) && (y >= WY_BEG) && (y < WY_END);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x            <= '0;
         y            <= '0;
         h_sync       <= ~HP;
         v_sync       <= ~VP;
         active_video <= 1'b0;
         pix_x        <= '0;
         pix_y        <= '0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         win_active   <= 1'b0;
         win_x        <= '0;
         win_y        <= '0;
      end else if (pix_ce) begin
         if (x == H_LAST) begin
            x <= '0;
            if (y == V_LAST) y <= '0;
            else             y <= y + ONE;
         end else begin
            x <= x + ONE;
         end
         h_sync       <= hs_d ? HP : ~HP;
         v_sync       <= vs_d ? VP : ~VP;
         active_video <= act_d;
         pix_x        <= x;
         pix_y        <= y;
         line_start   <= (x == '0);
         frame_start  <= (x == '0) && (y == '0);
         win_active   <= win_d;
         win_x        <= win_d ? (x - WX_BEG) : '0;
         win_y        <= win_d ? (y - WY_BEG) : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a tiny 14x7 raster
module tb_vga_timing_gen;

   localparam int CW = 5;
   localparam int HT = 14;
   localparam int VT = 7;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          av;
      logic          ls;
      logic          fs;
      logic          wa;
      logic [CW-1:0] px;
      logic [CW-1:0] py;
      logic [CW-1:0] wx;
      logic [CW-1:0] wy;
   } out_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pix_ce = 1'b0;
   logic          h_sync, v_sync, active_video, line_start, frame_start, win_active;
   logic [CW-1:0] pix_x, pix_y, win_x, win_y;

   int n_pass = 0;
   int n_total = 0;

   out_t exp_q[$];
   int   phase_q[$];
   out_t exp_cur;
   int   n_ce;
   int   phase = 0;
   int   cnt_hs = 0, cnt_vs = 0, cnt_fs = 0, cnt_win = 0, cnt_ls = 0;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1), .V_POL(1),
      .WIN_X0(2), .WIN_Y0(1), .WIN_W(3), .WIN_H(2),
      .CW(CW)
   ) dut (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .h_sync(h_sync), .v_sync(v_sync), .active_video(active_video),
      .pix_x(pix_x), .pix_y(pix_y),
      .line_start(line_start), .frame_start(frame_start),
      .win_active(win_active), .win_x(win_x), .win_y(win_y)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // Expected outputs derived from the ce count since reset (x = n mod 14, y = n/14 mod 7).
   function automatic out_t expect_at(input int n);
      out_t o;
      int   xx, yy;
      xx = n % HT;
      yy = (n / HT) % VT;
      o.hs = (xx == 10 || xx == 11);
      o.vs = (yy == 5);
      o.av = (xx < 8) && (yy < 4);
      o.ls = (xx == 0);
      o.fs = (xx == 0) && (yy == 0);
      o.wa = (xx >= 2 && xx <= 4) && (yy >= 1 && yy <= 2);
      o.px = CW'(xx);
      o.py = CW'(yy);
      o.wx = o.wa ? CW'(xx - 2) : '0;
      o.wy = o.wa ? CW'(yy - 1) : '0;
      return o;
   endfunction

   task automatic step(input logic r, input logic ce);
      reset  = r;
      pix_ce = ce;
      if (r) begin
         exp_cur = '0;
         n_ce = 0;
      end else if (ce) begin
         exp_cur = expect_at(n_ce);
         n_ce++;
      end
      exp_q.push_back(exp_cur);
      phase_q.push_back(phase);
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples 2 time units after each edge and pops the matching expectation.
   always @(posedge clk) begin
      out_t got, req;
      int   ph;
      #2;
      if (exp_q.size() > 0) begin
         req = exp_q.pop_front();
         ph  = phase_q.pop_front();
         got = '{h_sync, v_sync, active_video, line_start, frame_start, win_active,
                 pix_x, pix_y, win_x, win_y};
         check($sformatf("outputs_ph%0d", ph), 64'(got), 64'(req));
         if (ph == 2) begin
            cnt_hs  += int'(h_sync);
            cnt_vs  += int'(v_sync);
            cnt_fs  += int'(frame_start);
            cnt_win += int'(win_active);
            cnt_ls  += int'(line_start);
         end
      end
   end

   initial begin
      int wait_cnt;
      phase = 1;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("reset_h_sync", 64'(h_sync), 64'd0);
      check("reset_v_sync", 64'(v_sync), 64'd0);
      check("reset_active_video", 64'(active_video), 64'd0);

      phase = 2;
      for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'b1);
      phase = 3;
      check("first_ce_frame_start_after_2_frames", 64'(frame_start), 64'd0);
      check("h_sync_high_count_2frames", 64'(cnt_hs), 64'd28);
      check("v_sync_high_count_2frames", 64'(cnt_vs), 64'd28);
      check("frame_start_count_2frames", 64'(cnt_fs), 64'd2);
      check("win_active_count_2frames", 64'(cnt_win), 64'd12);
      check("line_start_count_2frames", 64'(cnt_ls), 64'd14);

      // Restart, then pix_ce toggling 1,0 for one frame: outputs hold on ce-low cycles.
      step(1'b1, 1'b0);
      for (int i = 0; i < HT * VT; i++) begin
         step(1'b0, 1'b1);
         step(1'b0, 1'b0);
      end

      // Reset mid-line with ce high takes priority, then first ce presents (0,0).
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check("midframe_reset_pix_x", 64'(pix_x), 64'd0);
      step(1'b0, 1'b1);
      check("after_reset_frame_start", 64'(frame_start), 64'd1);
      check("after_reset_active_video", 64'(active_video), 64'd1);
      for (int i = 0; i < 30; i++) step(1'b0, ($urandom_range(0, 1) == 1));

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #3;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 sync generator. Produces h_sync/v_sync with configurable porch, pulse widths and polarity, plus active_video, absolute pixel coordinates and frame/line start strobes. Adds a rectangular region-of-interest window (win_active, window-relative coordinates), sized for the sobel output tile, and a pixel clock-enable so it can run from a faster system clock. Sits between the pixel pipeline and the VGA DAC pins; the sobel frame-buffer read logic consumes its coordinates.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, h_sync active level (0 = active-low)
V_POL, 0, v_sync active level (0 = active-low)
WIN_X0, 288, window left column (absolute)
WIN_Y0, 208, window top line (absolute)
WIN_W, 64, window width (pixels)
WIN_H, 64, window height (lines)
CW, 11, coordinate/counter width (bits)

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel enable; counters and outputs advance only when high
h_sync  out  1  horizontal sync, polarity per H_POL
v_sync  out  1  vertical sync, polarity per V_POL
active_video  out  1  high inside H_ACTIVE x V_ACTIVE
pix_x  out  CW  absolute column of current output pixel
pix_y  out  CW  absolute line of current output pixel
line_start  out  1  one-ce pulse at x==0 of every line
frame_start  out  1  one-ce pulse at x==0,y==0
win_active  out  1  high inside window rectangle
win_x  out  CW  pix_x - WIN_X0 when win_active, else 0
win_y  out  CW  pix_y - WIN_Y0 when win_active, else 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters x in 0..H_TOTAL-1, y in 0..V_TOTAL-1 (no off-by-one: exactly H_TOTAL pixels/line, V_TOTAL lines/frame).
- Per pix_ce cycle: x increments; at x==H_TOTAL-1, x->0 and y increments; at y==V_TOTAL-1 with x wrap, y->0. pix_ce low: counters and all outputs hold (strobes held too — consumers qualify with pix_ce).
- Decode (of pre-advance position p=(x,y)), registered on the same pix_ce edge, so outputs lag counters by exactly one ce cycle:
  active_video = x<H_ACTIVE && y<V_ACTIVE;
  h_sync asserted when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC;
  v_sync asserted when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (whole lines);
  win_active = WIN_X0<=x<WIN_X0+WIN_W && WIN_Y0<=y<WIN_Y0+WIN_H;
  line_start = x==0; frame_start = x==0 && y==0; pix_x/pix_y = x/y.
- All comparisons unsigned, CW bits; CW must hold H_TOTAL-1 and V_TOTAL-1. Window must lie inside active area; elaboration-time check ($error) if WIN_X0+WIN_W>H_ACTIVE, WIN_Y0+WIN_H>V_ACTIVE, or 2**CW<=max(H_TOTAL,V_TOTAL).
- Reset (sync, priority over pix_ce): x=y=0; h_sync=!H_POL, v_sync=!V_POL (deasserted); active_video, win_active, line_start, frame_start = 0; pix_x, pix_y, win_x, win_y = 0. First pix_ce after reset presents position (0,0): active_video=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: next edge returns to reset state regardless of pix_ce; no partial sync pulse completion.
- Free-running state machine only (no handshake); frame rate = f_clk*duty(pix_ce)/(H_TOTAL*V_TOTAL).

Test Plan:
- Defaults, pix_ce=1, reset 2 cycles then run 2 frames -> line period 800 clocks, frame 420000 clocks; h_sync low for exactly 96 clocks beginning at output pix_x=656; v_sync low for exactly 2 lines beginning at pix_y=490.
- First ce after reset -> frame_start=1, line_start=1, active_video=1, pix_x=0, pix_y=0; frame_start next at exactly 420000 ce later, never otherwise.
- Window defaults -> win_active high for pix_x 288..351 on lines 208..271 (4096 pixels/frame); at pix_x=288,pix_y=208 win_x=0,win_y=0; at (351,271) win_x=63,win_y=63; outside window win_x=win_y=0.
- pix_ce toggling 1,0 -> all outputs change only on ce edges, line period 1600 clocks, pulse widths in clocks doubled.
- H_POL=1,V_POL=1, tiny timing (H 8/2/2/2, V 4/1/1/1) -> h_sync high only at x=10..11, v_sync high only on y=5; reset value h_sync=v_sync=0.
- Reset asserted at pix_x=500,pix_y=300 for 1 cycle -> next cycle all outputs at reset values, following ce gives frame_start=1 at (0,0).
